hog_block_gen: RTL and testbench

HOG_BLOCK_GEN -- requirements
Module: hog_block_gen

---
 rtl/hog_block_gen.sv | 113 +++++++++++
 tb/tb_hog_block_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hog_block_gen.sv
// Groups a raster stream of HOG cell histograms into overlapping 2x2 blocks using a one-row line buffer.
// Optional HOG_BLOCK_GEN_BID_EN adds an o_bid block-index output.
module hog_block_gen #(
  parameter int FEA_I     = 4,
  parameter int FEA_F     = 28,
  parameter int CELL_COLS = 8,
  parameter int CELL_ROWS = 16,
  parameter int BID_W     = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9*(FEA_I+FEA_F)-1:0]   i_cell,
  input  logic                         i_valid,
  input  logic                         i_sof,
  output logic [9*(FEA_I+FEA_F)-1:0]   fea_a,
  output logic [9*(FEA_I+FEA_F)-1:0]   fea_b,
  output logic [9*(FEA_I+FEA_F)-1:0]   fea_c,
  output logic [9*(FEA_I+FEA_F)-1:0]   fea_d,
  output logic                         o_valid,
  output logic                         o_eof
`ifdef HOG_BLOCK_GEN_BID_EN
  ,
  output logic [BID_W-1:0]             o_bid
`endif
);

  localparam int CW    = 9*(FEA_I+FEA_F);
  localparam int COL_W = (CELL_COLS > 1) ? $clog2(CELL_COLS) : 1;
  localparam int ROW_W = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;

  logic [CW-1:0]    line_buf [CELL_COLS];
  logic [CW-1:0]    left_cell;
  logic [CW-1:0]    upleft_cell;
  logic [CW-1:0]    old_cell;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] acc_col;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] acc_row;
  logic             col_last;
  logic             row_last;
  logic             emit;

  // A start-of-frame cell overrides the counters so the partial frame is abandoned.
  always_comb begin
    acc_col  = i_sof ? '0 : col;
    acc_row  = i_sof ? '0 : row;
    old_cell = line_buf[acc_col];
    col_last = (acc_col == COL_W'(CELL_COLS-1));
    row_last = (acc_row == ROW_W'(CELL_ROWS-1));
    emit     = (acc_row != '0) && (acc_col != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst && i_valid)
      line_buf[acc_col] <= i_cell;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      left_cell   <= '0;
      upleft_cell <= '0;
      fea_a       <= '0;
      fea_b       <= '0;
      fea_c       <= '0;
      fea_d       <= '0;
      o_valid     <= 1'b0;
      o_eof       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_eof   <= 1'b0;
      if (i_valid) begin
        left_cell   <= i_cell;
        upleft_cell <= old_cell;
        if (emit) begin
          fea_a   <= upleft_cell;
          fea_b   <= old_cell;
          fea_c   <= left_cell;
          fea_d   <= i_cell;
          o_valid <= 1'b1;
          o_eof   <= row_last && col_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : acc_row + 1'b1;
        end else begin
          col <= acc_col + 1'b1;
          row <= acc_row;
        end
      end
    end
  end

`ifdef HOG_BLOCK_GEN_BID_EN
  logic [BID_W-1:0] bid_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bid_cnt <= '0;
      o_bid   <= '0;
    end else if (i_valid) begin
      if (emit) begin
        o_bid   <= bid_cnt;
        bid_cnt <= (row_last && col_last) ? '0 : bid_cnt + 1'b1;
      end else if (i_sof) begin
        bid_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hog_block_gen.sv
// Randomized scoreboard bench for hog_block_gen: a grid model predicts every 2x2 block and its timing.
module tb_hog_block_gen;

  localparam int W    = 32;
  localparam int CW   = 9*W;
  localparam int COLS = 8;
  localparam int ROWS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] i_cell;
  logic          i_valid;
  logic          i_sof;
  logic [CW-1:0] fea_a, fea_b, fea_c, fea_d;
  logic          o_valid;
  logic          o_eof;
`ifdef HOG_BLOCK_GEN_BID_EN
  logic [12:0]   o_bid;
`endif

  hog_block_gen #(.FEA_I(4), .FEA_F(28), .CELL_COLS(COLS), .CELL_ROWS(ROWS), .BID_W(13)) dut (
    .clk(clk), .rst(rst), .i_cell(i_cell), .i_valid(i_valid), .i_sof(i_sof),
    .fea_a(fea_a), .fea_b(fea_b), .fea_c(fea_c), .fea_d(fea_d),
    .o_valid(o_valid), .o_eof(o_eof)
`ifdef HOG_BLOCK_GEN_BID_EN
    , .o_bid(o_bid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] a, b, c, d;
    logic          eof;
    int            bid;
    longint        stamp;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] grid [ROWS][COLS];
  int            mr, mc;
  longint        cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            nblk = 0;
  int            neof = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] rep(input int k);
    logic [W-1:0] kk;
    kk = W'(k);
    return {9{kk}};
  endfunction

  function automatic logic [CW-1:0] rnd_cell();
    logic [CW-1:0] v;
    for (int i = 0; i < 9; i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: remember every cell by its frame position; a block at (r,c) is the 2x2 window ending there.
  task automatic send(input logic [CW-1:0] v, input logic sof);
    exp_t e;
    i_cell  = v;
    i_valid = 1'b1;
    i_sof   = sof;
    if (sof) begin mr = 0; mc = 0; end
    grid[mr][mc] = v;
    if (mr >= 1 && mc >= 1) begin
      e.a = grid[mr-1][mc-1];
      e.b = grid[mr-1][mc];
      e.c = grid[mr][mc-1];
      e.d = v;
      e.eof = (mr == ROWS-1) && (mc == COLS-1);
      e.bid = (mr-1)*(COLS-1) + (mc-1);
      e.stamp = cyc + 1;
      sb.push_back(e);
    end
    mc++;
    if (mc == COLS) begin
      mc = 0;
      mr = (mr == ROWS-1) ? 0 : mr + 1;
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  // Idle cycles carry a random i_sof that must be ignored.
  task automatic idle(input int n);
    i_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      i_sof  = 1'($urandom_range(0, 1));
      i_cell = rnd_cell();
      @(negedge clk);
    end
    i_sof = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, CW'(o_valid), '0);
    chk({tag, "_eof"},   CW'(o_eof), '0);
    chk({tag, "_fea_a"}, fea_a, '0);
    chk({tag, "_fea_b"}, fea_b, '0);
    chk({tag, "_fea_c"}, fea_c, '0);
    chk({tag, "_fea_d"}, fea_d, '0);
`ifdef HOG_BLOCK_GEN_BID_EN
    chk({tag, "_bid"},   CW'(o_bid), '0);
`endif
  endtask

  task automatic chk_counts(input string tag, input int blk, input int eofs);
    chk({tag, "_blocks"}, CW'(nblk), CW'(blk));
    chk({tag, "_eofs"},   CW'(neof), CW'(eofs));
  endtask

  // Monitor: every o_valid pulse must match the oldest predicted block and arrive on its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        nblk++;
        if (o_eof === 1'b1) neof++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block actual=o_valid required=no_block");
        end else begin
          e = sb.pop_front();
          chk("fea_a", fea_a, e.a);
          chk("fea_b", fea_b, e.b);
          chk("fea_c", fea_c, e.c);
          chk("fea_d", fea_d, e.d);
          chk("eof",   CW'(o_eof), CW'(e.eof));
          chk("latency", CW'(cyc), CW'(e.stamp));
`ifdef HOG_BLOCK_GEN_BID_EN
          chk("bid",   CW'(o_bid), CW'(e.bid));
`endif
        end
      end
    end
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_cell = '0;
    mr = 0; mc = 0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Frame of k-valued cells, back-to-back.
    nblk = 0; neof = 0;
    for (int k = 0; k < ROWS*COLS; k++) send(rep(k), 1'b0);
    idle(3);
    chk_counts("frame1", 105, 1);
    chk("hold_a", fea_a, rep(118));
    chk("hold_b", fea_b, rep(119));
    chk("hold_c", fea_c, rep(126));
    chk("hold_d", fea_d, rep(127));

    // Same frame with random gaps.
    nblk = 0; neof = 0;
    for (int k = 0; k < ROWS*COLS; k++) begin
      send(rep(k), 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(3);
    chk_counts("gaps", 105, 1);

    // Partial frame abandoned by i_sof.
    nblk = 0; neof = 0;
    for (int k = 0; k < 40; k++) send(rnd_cell(), 1'b0);
    idle(3);
    nblk = 0; neof = 0;
    for (int k = 0; k < ROWS*COLS; k++) begin
      send(rep(k), k == 0);
      idle($urandom_range(0, 2));
    end
    idle(3);
    chk_counts("sof", 105, 1);

    // Reset mid-frame with a cell presented during reset.
    for (int k = 0; k < 50; k++) send(rnd_cell(), 1'b0);
    i_cell = rnd_cell(); i_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    chk_zero_outputs("midrst");
    mr = 0; mc = 0;
    nblk = 0; neof = 0;
    for (int k = 0; k < ROWS*COLS; k++) send(rep(k), 1'b0);
    idle(3);
    chk_counts("after_rst", 105, 1);

    // Two back-to-back random frames with no i_sof.
    nblk = 0; neof = 0;
    for (int k = 0; k < 2*ROWS*COLS; k++) begin
      send(rnd_cell(), 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk_counts("two_frames", 210, 2);

    chk("scoreboard_empty", CW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
